// File: rtl/sfp_link_manager.sv
// sfp_link_manager: four-port SFP presence debounce, one-at-a-time laser bring-up and link retry control
module sfp_link_manager #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int SETTLE_TICKS   = 300,
  parameter int LOS_WAIT_TICKS = 100,
  parameter int RETRY_TICKS    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] detect_i,
  input  logic [3:0] los_i,
  input  logic [3:0] force_off_i,
  output logic [3:0] disable_o,
  output logic [3:0] present_o,
  output logic [3:0] link_up_o,
  output logic [3:0] fault_o,
  output logic [3:0] grant_o
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int MT = SETTLE_TICKS > LOS_WAIT_TICKS
    ? (SETTLE_TICKS > RETRY_TICKS ? SETTLE_TICKS : RETRY_TICKS)
    : (LOS_WAIT_TICKS > RETRY_TICKS ? LOS_WAIT_TICKS : RETRY_TICKS);
  localparam int CW = $clog2(MT + 1);
  localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_END = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] SET_END = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] LOS_END = CW'(LOS_WAIT_TICKS - 1);
  localparam logic [CW-1:0] RET_END = CW'(RETRY_TICKS - 1);
  // bits [3:0] carry module present, bits [7:4] carry LOS
  localparam logic [7:0] IN_RST = 8'hf0;

  typedef enum logic [2:0] {ABSENT, SETTLE, WAIT_GRANT, BRINGUP, UP, BACKOFF} state_t;

  logic [PW-1:0] pre_q;
  logic          tick_q;
  logic [7:0]    s1_q, s2_q, deb_q;
  logic [DW-1:0] dcnt_q [8];
  state_t        st_q [4];
  state_t        st_d [4];
  logic [CW-1:0] cnt_q [4];
  logic [3:0]    flt_q, flt_d, grant_q, grant_d;
  logic [1:0]    ptr_q, ptr_d, idx;

  assign present_o = deb_q[3:0];
  assign grant_o   = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      s1_q   <= IN_RST;
      s2_q   <= IN_RST;
    end else begin
      pre_q  <= pre_q == PRE_END ? '0 : pre_q + 1'b1;
      tick_q <= pre_q == PRE_END;
      s1_q   <= {los_i, ~detect_i};
      s2_q   <= s1_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (rst) begin
        dcnt_q[b] <= '0;
        deb_q[b]  <= IN_RST[b];
      end else if (tick_q) begin
        dcnt_q[b] <= s2_q[b] != deb_q[b] && dcnt_q[b] != DEB_END ? dcnt_q[b] + 1'b1 : '0;
        if (s2_q[b] != deb_q[b] && dcnt_q[b] == DEB_END) deb_q[b] <= s2_q[b];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      st_d[p]  = st_q[p];
      flt_d[p] = flt_q[p];
      if (!deb_q[p] || force_off_i[p]) begin
        st_d[p]  = ABSENT;
        flt_d[p] = 1'b0;
      end else begin
        case (st_q[p])
          ABSENT:     st_d[p] = SETTLE;
          SETTLE:     if (tick_q && cnt_q[p] == SET_END) st_d[p] = WAIT_GRANT;
          WAIT_GRANT: if (grant_q[p]) st_d[p] = BRINGUP;
          BRINGUP:
            if (!deb_q[4+p]) begin
              st_d[p]  = UP;
              flt_d[p] = 1'b0;
            end else if (tick_q && cnt_q[p] == LOS_END) begin
              st_d[p]  = BACKOFF;
              flt_d[p] = 1'b1;
            end
          UP:
            if (deb_q[4+p]) begin
              st_d[p]  = BACKOFF;
              flt_d[p] = 1'b1;
            end
          BACKOFF:    if (tick_q && cnt_q[p] == RET_END) st_d[p] = WAIT_GRANT;
          default:    st_d[p] = ABSENT;
        endcase
      end
    end
  end

  // an idle slot is only refilled from a grant-free cycle, which guarantees the gap between owners
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    if (|grant_q) begin
      for (int p = 0; p < 4; p++)
        grant_d[p] = grant_q[p] && (st_q[p] == WAIT_GRANT || st_q[p] == BRINGUP);
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr_q + 2'(k);
        if (st_q[idx] == WAIT_GRANT) begin
          grant_d = 4'b0001 << idx;
          ptr_d   = idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      flt_q     <= '0;
      disable_o <= 4'hf;
      link_up_o <= '0;
      fault_o   <= '0;
      for (int p = 0; p < 4; p++) begin
        st_q[p]  <= ABSENT;
        cnt_q[p] <= '0;
      end
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      flt_q   <= flt_d;
      fault_o <= flt_q;
      for (int p = 0; p < 4; p++) begin
        st_q[p]      <= st_d[p];
        cnt_q[p]     <= st_d[p] != st_q[p] ? '0 : cnt_q[p] + CW'(tick_q);
        disable_o[p] <= !(st_q[p] == BRINGUP || st_q[p] == UP);
        link_up_o[p] <= st_q[p] == UP;
      end
    end
  end
endmodule

// File: tb/tb_sfp_link_manager.sv
// tb_sfp_link_manager: scoreboard bench; stimulus queues timed output snapshots, a monitor pops one per output change
module tb_sfp_link_manager;
  localparam logic [19:0] RST_VEC = 20'hF0000;
  typedef struct {int c; logic [19:0] v;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] detect_i = 4'hF, los_i = 4'hF, force_off_i = 4'h0;
  logic [3:0] disable_o, present_o, link_up_o, fault_o, grant_o;
  logic [19:0] vec, prev, exp_vec;
  exp_t exp_q[$];
  exp_t e;
  int cyc = 0, base = 0, checks = 0, errors = 0;
  bit mon_en = 1'b0;

  sfp_link_manager #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(2), .SETTLE_TICKS(3), .LOS_WAIT_TICKS(5), .RETRY_TICKS(6)
  ) dut (
    .clk(clk), .rst(rst), .detect_i(detect_i), .los_i(los_i), .force_off_i(force_off_i),
    .disable_o(disable_o), .present_o(present_o), .link_up_o(link_up_o), .fault_o(fault_o),
    .grant_o(grant_o)
  );

  // snapshot layout, one hex digit each: {disable, present, link_up, fault, grant}
  assign vec = {disable_o, present_o, link_up_o, fault_o, grant_o};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(grant_o)) begin
        errors++;
        $display("FAIL grant_onehot cyc=%0d got=%b exp=at most one bit", cyc, grant_o);
      end
      if (vec !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h exp=no change", cyc, vec);
        end else begin
          e = exp_q.pop_front();
          if (vec !== e.v || cyc != e.c) begin
            errors++;
            $display("FAIL output_event got=%h@%0d exp=%h@%0d", vec, cyc, e.v, e.c);
          end
        end
      end
    end
    prev = vec;
  end

  task automatic push(input int c, input logic [19:0] v);
    exp_q.push_back('{c, v});
    exp_vec = v;
  endtask

  task automatic ev(input int k, input logic [19:0] v);
    push(base + k, v);
  endtask

  task automatic at(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic go(input logic [3:0] det, input logic [3:0] los);
    rst = 1'b0;
    detect_i = det;
    los_i = los;
    force_off_i = 4'h0;
    base = cyc;
  endtask

  task automatic restart(input logic [3:0] det, input logic [3:0] los);
    @(posedge clk);
    #1;
    rst = 1'b1;
    if (exp_vec !== RST_VEC) push(cyc + 1, RST_VEC);
    @(posedge clk);
    #1;
    go(det, los);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    exp_vec = RST_VEC;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vec got=%h exp=%h", vec, RST_VEC);
    end
    mon_en = 1'b1;
    // single port bring-up with good signal
    go(4'hE, 4'hE);
    ev(9, 20'hF1000); ev(22, 20'hF1001); ev(24, 20'hE1001); ev(25, 20'hE1100);
    drain();
    // all ports inserted together, no light: round-robin, timeouts and retry
    restart(4'h0, 4'hF);
    ev(9, 20'hFF000);  ev(22, 20'hFF001);  ev(24, 20'hEF001);
    ev(42, 20'hFF010); ev(43, 20'hFF012);  ev(45, 20'hDF012);
    ev(62, 20'hFF030); ev(63, 20'hFF034);  ev(65, 20'hBF034);
    ev(82, 20'hFF070); ev(83, 20'hFF078);  ev(85, 20'h7F078);
    ev(102, 20'hFF0F0); ev(103, 20'hFF0F1); ev(105, 20'hEF0F1);
    drain();
    // port 2 up, loses light, recovers before retry
    restart(4'hB, 4'hB);
    ev(9, 20'hF4000);  ev(22, 20'hF4004); ev(24, 20'hB4004); ev(25, 20'hB4400);
    ev(39, 20'hF4040); ev(62, 20'hF4044); ev(64, 20'hB4044); ev(65, 20'hB4400);
    at(30); los_i[2] = 1'b1;
    at(40); los_i[2] = 1'b0;
    drain();
    // operator disable of the grant owner hands the slot to the waiting port
    restart(4'h5, 4'hF);
    ev(9, 20'hFA000); ev(22, 20'hFA002); ev(24, 20'hDA002);
    ev(28, 20'hFA000); ev(29, 20'hFA008); ev(31, 20'h7A008);
    at(26); force_off_i[1] = 1'b1;
    at(27); force_off_i[1] = 1'b0;
    drain();
    // detect glitch shorter than the debounce window
    restart(4'hF, 4'hF);
    at(6); detect_i[0] = 1'b0;
    at(10); detect_i[0] = 1'b1;
    at(40);
    checks++;
    if (vec !== RST_VEC) begin
      errors++;
      $display("FAIL glitch_quiet got=%h exp=%h", vec, RST_VEC);
    end
    drain();
    // reset while port 0 is in bring-up
    restart(4'hE, 4'hF);
    ev(9, 20'hF1000); ev(22, 20'hF1001); ev(24, 20'hE1001);
    at(26);
    rst = 1'b1;
    push(cyc + 1, RST_VEC);
    drain();
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfp_link_manager.md
# sfp_link_manager

Four-port SFP bring-up controller for the SFP cage board, sitting between the raw cage pins (MOD_ABS, LOS, TX_DISABLE) and the per-port `sfp` blocks and LEDs. It debounces module presence, enforces the power-up settle time, and drives each port's TX_DISABLE. A round-robin arbiter admits one laser turn-on at a time to limit inrush. Link monitoring puts failed ports into timed back-off and retry.

## Interface
- `TICK_DIV`, 100000: clk cycles per timebase tick (1 ms at 100 MHz).
- `DEBOUNCE_TICKS`, 10: consecutive equal tick samples needed to change a debounced input.
- `SETTLE_TICKS`, 300: ticks from debounced insertion to bring-up request.
- `LOS_WAIT_TICKS`, 100: ticks allowed in BRINGUP for LOS to clear.
- `RETRY_TICKS`, 1000: back-off ticks before re-requesting bring-up.
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: synchronous, active-high reset.
- `detect` in 4: raw MOD_ABS per port, asynchronous; low = module present.
- `los` in 4: raw LOS per port, asynchronous; high = loss of signal.
- `force_off` in 4: per-port operator disable (DP switches); high = hold port off.
- `disable` out 4: TX_DISABLE per port; high = laser off.
- `present` out 4: debounced module present.
- `link_up` out 4: port in UP state.
- `fault` out 4: port failed bring-up or lost link; sticky, see Operation.
- `grant` out 4: one-hot bring-up slot owner; 0 = slot free.

## Operation
- Each `detect` and `los` bit passes through a 2-flop synchroniser, then a tick-sampled debouncer. The debounced value changes only after `DEBOUNCE_TICKS` consecutive samples that differ from it.
- Debounced reset values: present = 0, los = 1.
- Shared prescaler produces a 1-cycle `tick` every `TICK_DIV` clocks.
- One per-port FSM per port; each has a tick counter that clears on every state entry.
- ABSENT: disable = 1.
  - Goes to SETTLE when debounced present = 1 and force_off = 0.
- SETTLE: disable = 1.
  - Goes to WAIT_GRANT when the counter reaches `SETTLE_TICKS`.
- WAIT_GRANT: disable = 1, arbiter request asserted.
  - Goes to BRINGUP in the cycle `grant` for this port is seen high.
- BRINGUP: disable = 0; the port holds the grant.
  - Debounced los = 0 → UP; fault cleared.
  - Counter reaches `LOS_WAIT_TICKS` first → BACKOFF; fault set.
- UP: disable = 0, link_up = 1.
  - Debounced los = 1 → BACKOFF; fault set.
- BACKOFF: disable = 1.
  - Goes to WAIT_GRANT when the counter reaches `RETRY_TICKS`.
- Override, all states: debounced present = 0 or force_off = 1 → ABSENT next cycle.
  - This clears fault and drops any grant held.
- Arbiter: round-robin across ports in WAIT_GRANT.
  - Search starts at (last owner + 1) mod 4; the pointer starts at port 0 after reset.
  - The grant is held while the owner is in BRINGUP and drops the cycle after the owner leaves BRINGUP.
  - A new grant is issued no earlier than the following cycle, so there is at least one grant-free cycle between owners.
  - At most one `grant` bit is ever high.

## Timing
- Reset values: disable = 4'b1111, present = 0, link_up = 0, fault = 0, grant = 0, all FSMs in ABSENT, prescaler = 0.
- First tick occurs `TICK_DIV` cycles after `rst` deasserts.
- Input to synchronised value: 2 cycles. The debounce change lands on the `DEBOUNCE_TICKS`-th qualifying tick.
- Counter thresholds are evaluated on tick cycles only. Real duration from state entry is between N-1 and N tick periods.
- All outputs are registered; FSM state to output is 1 cycle.
- Grant issue: request visible → `grant` high next cycle → FSM in BRINGUP next cycle → `disable` low next cycle.
- Simultaneous events in one cycle:
  - Override beats every other transition.
  - In BRINGUP, los clearing on the same tick as the timeout → UP.
- `rst` asserted mid-operation returns everything to reset values on the next edge, including dropping the grant and setting disable high.

## Test plan
Parameters: TICK_DIV = 4, DEBOUNCE_TICKS = 2, SETTLE_TICKS = 3, LOS_WAIT_TICKS = 5, RETRY_TICKS = 6.
- Reset, then port 0 detect low, los low → present[0] after 2 ticks, grant = 4'b0001 after 3 more ticks, disable[0] = 0, then link_up[0] = 1 and grant = 0.
- All four ports inserted in the same cycle, los high → grants issued in order 0001, 0010, 0100, 1000, with never two bits set and a gap cycle between owners. Each port times out after 5 ticks with fault = 1 and disable = 1, then re-requests 6 ticks later.
- Port 2 in UP, los held high ≥ 2 ticks → link_up[2] = 0, fault[2] = 1, disable[2] = 1. Clearing los before the retry leads to UP again with fault[2] = 0.
- force_off[1] pulsed while port 1 owns the grant → ABSENT next cycle, grant drops, waiting port 3 is granted after the gap cycle.
- Glitch on detect shorter than 2 ticks → present unchanged and no FSM activity.
- `rst` asserted with port 0 in BRINGUP → next cycle disable = 4'b1111, grant = 0, link_up = 0, fault = 0.
